// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if -- bundle of the CPU request/response handshake and the
// word-addressed data memory port served by lsu_mem_master.
//
// Signals:
//   req_valid/req_ready        request handshake (accept when both high)
//   req_write, req_size,       store/load, 0=byte 1=half 2=word 3=illegal,
//   req_unsigned               zero- (1) or sign- (0) extension for loads
//   req_addr, req_wdata        byte address, right-aligned store data
//   resp_valid/rdata/err       one-cycle completion pulse with load data/error
//   mem_write_en/addr/         memory write strobe, word index, full write word
//   mem_write_data
//   mem_read_data              combinational read of mem[mem_addr]
//
// Modports:
//   master -- the load/store unit (drives responses and the memory port)
//   slave  -- its environment (CPU pipeline issuing requests + data memory)
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_write_en, mem_addr, mem_write_data
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_write_en, mem_addr, mem_write_data
  );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master -- load/store initiator for the word-addressed data memory.
//
// Accepts one byte/halfword/word request at a time, converts the byte address
// to a word index, performs sub-word stores as read-modify-write and returns
// loads sign- or zero-extended. One request in flight; responses cannot be
// back-pressured.
//
// Ports:
//   clk    single clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    lsu_mem_master_if.master (request/response + memory port)
//
// Parameter:
//   MEM_WORDS  number of 32-bit words in the data memory (default `DATA_MEM_SIZE)
//
// Optional feature:
//   LSU_ADDR_CHECK_EN  when defined, a word index >= MEM_WORDS is reported
//                      through resp_err and never reaches the memory.
//
// Latency from the accepting edge T to the resp_valid cycle:
//   error T+1, load T+2, word store T+2, sub-word store T+3.
`ifndef DATA_MEM_SIZE
`define DATA_MEM_SIZE 1024
`endif

module lsu_mem_master #(
  parameter int MEM_WORDS = `DATA_MEM_SIZE
) (
  input logic              clk,
  input logic              rst_n,
  lsu_mem_master_if.master bus
);

  if (MEM_WORDS < 1) begin : g_bad_cfg
    $error("lsu_mem_master: MEM_WORDS must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  // Request decode, valid only while idle.
  logic [31:0] req_idx;
  logic        align_err;
  logic        range_err;
  logic        req_err;

  always_comb begin
    req_idx = {2'b00, bus.req_addr[31:2]};
    unique case (bus.req_size)
      SZ_BYTE: align_err = 1'b0;
      SZ_HALF: align_err = bus.req_addr[0];
      SZ_WORD: align_err = (bus.req_addr[1:0] != 2'b00);
      default: align_err = 1'b1;
    endcase
  end

`ifdef LSU_ADDR_CHECK_EN
  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);
  assign range_err = (req_idx >= MEM_WORDS_W);
`else
  // No range check: the index goes to the memory unmodified.
  assign range_err = 1'b0;
`endif

  assign req_err = align_err | range_err;

  // Lane alignment for the captured request: load extraction and store merge.
  logic [4:0]  lane_shift;
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  always_comb begin
    lane_shift = {lane_q, 3'b000};
    rd_shifted = bus.mem_read_data >> lane_shift;
    unique case (size_q)
      SZ_BYTE: load_ext = unsigned_q ? {24'h0, rd_shifted[7:0]}
                                     : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      SZ_HALF: load_ext = unsigned_q ? {16'h0, rd_shifted[15:0]}
                                     : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = bus.mem_read_data;
    endcase
    lane_mask = (size_q == SZ_BYTE) ? (32'h0000_00FF << lane_shift)
                                    : (32'h0000_FFFF << lane_shift);
    // Only the addressed lane(s) take store data; the rest keep memory contents.
    merged = (bus.mem_read_data & ~lane_mask) | ((wdata_q << lane_shift) & lane_mask);
  end

  // Next-state and datapath updates.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    state_d    = state_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    lane_d     = lane_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          size_d     = bus.req_size;
          unsigned_d = bus.req_unsigned;
          lane_d     = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata;
          err_d      = req_err;
          rdata_d    = 32'h0;
          if (req_err) begin
            // mem_addr keeps its previous value: an erroring request never
            // touches the memory.
            state_d = S_RESP;
          end else begin
            addr_d = req_idx;
            if (!bus.req_write) begin
              state_d = S_LOAD;
            end else if (bus.req_size == SZ_WORD) begin
              wr_data_d = bus.req_wdata;
              state_d   = S_WR;
            end else begin
              state_d = S_RMW_RD;
            end
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_ext;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        wr_data_d = merged;
        state_d   = S_WR;
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      addr_q     <= 32'h0;
      wr_data_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      lane_q     <= lane_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Outputs decode straight from registered state, so reset drops the write
  // strobe immediately.
  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.resp_valid     = (state_q == S_RESP);
  assign bus.resp_rdata     = rdata_q;
  assign bus.resp_err       = err_q;
  assign bus.mem_write_en   = (state_q == S_WR);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wr_data_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master -- directed self-checking bench for lsu_mem_master.
// A small word memory model serves the memory port; each request records its
// response latency, write strobes seen and response data, which are compared
// against hand-computed values.
module tb_lsu_mem_master;
  localparam int          MEM_WORDS   = 64;
  localparam logic [31:0] MEM_WORDS_W = 32'd64;

  logic clk;
  logic rst_n;

  lsu_mem_master_if bus ();

  lsu_mem_master #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: combinational read, write on the rising edge.
  logic [31:0] mem [MEM_WORDS];
  assign bus.mem_read_data = (bus.mem_addr < MEM_WORDS_W) ? mem[bus.mem_addr[5:0]] : 32'h0;
  always @(posedge clk) begin
    if (rst_n && bus.mem_write_en === 1'b1 && bus.mem_addr < MEM_WORDS_W)
      mem[bus.mem_addr[5:0]] <= bus.mem_write_data;
  end

  int vectors     = 0;
  int miscompares = 0;

  // Per-transaction observations.
  int          lat;
  int          wr_cnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        busy_ok;
  logic [31:0] saved;
  int          seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request (caller sits just after a rising edge) and watch it to
  // completion within a bounded number of cycles.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    lat = 0; wr_cnt = 0; wr_addr = '0; wr_data = '0;
    r_rdata = '0; r_err = 1'b0; busy_ok = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'h1357_9BDF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.req_ready !== 1'b0) busy_ok = 1'b0;
      if (bus.mem_write_en === 1'b1) begin
        wr_cnt++;
        wr_addr = bus.mem_addr;
        wr_data = bus.mem_write_data;
      end
      if (bus.resp_valid === 1'b1) begin
        lat     = k;
        r_rdata = bus.resp_rdata;
        r_err   = bus.resp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",    {31'h0, bus.req_ready},    32'h1);
    check("rst_resp_v",   {31'h0, bus.resp_valid},   32'h0);
    check("rst_rdata",    bus.resp_rdata,            32'h0);
    check("rst_err",      {31'h0, bus.resp_err},     32'h0);
    check("rst_wen",      {31'h0, bus.mem_write_en}, 32'h0);
    check("rst_addr",     bus.mem_addr,              32'h0);
    check("rst_wdata",    bus.mem_write_data,        32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Word store 0xDEADBEEF to 0x10.
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check("sw_lat",     32'(lat),            32'd2);
    check("sw_wcnt",    32'(wr_cnt),         32'd1);
    check("sw_waddr",   wr_addr,             32'd4);
    check("sw_wdata",   wr_data,             32'hDEAD_BEEF);
    check("sw_err",     {31'h0, r_err},      32'h0);
    check("sw_rdata",   r_rdata,             32'h0);
    check("sw_busy",    {31'h0, busy_ok},    32'h1);
    check("sw_mem",     mem[4],              32'hDEAD_BEEF);
    check("sw_ready",   {31'h0, bus.req_ready}, 32'h1);

    // Word load from 0x10.
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("lw_lat",     32'(lat),       32'd2);
    check("lw_rdata",   r_rdata,        32'hDEAD_BEEF);
    check("lw_err",     {31'h0, r_err}, 32'h0);
    check("lw_wcnt",    32'(wr_cnt),    32'd0);

    // Byte store 0x5A to 0x12; upper store-data bits must not leak.
    run_req(1'b1, 2'd0, 1'b0, 32'h12, 32'hFFFF_FF5A);
    check("sb_lat",     32'(lat),     32'd3);
    check("sb_wcnt",    32'(wr_cnt),  32'd1);
    check("sb_waddr",   wr_addr,      32'd4);
    check("sb_wdata",   wr_data,      32'hDE5A_BEEF);
    check("sb_mem",     mem[4],       32'hDE5A_BEEF);

    // Extension cases on mem[4] = 0xDE5ABEEF.
    run_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    check("lh_s_12",    r_rdata,      32'hFFFF_DE5A);
    run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    check("lh_u_12",    r_rdata,      32'h0000_DE5A);
    run_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    check("lb_u_13",    r_rdata,      32'h0000_00DE);
    run_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    check("lb_s_10",    r_rdata,      32'hFFFF_FFEF);
    check("lb_s_lat",   32'(lat),     32'd2);
    run_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    check("lb_s_11",    r_rdata,      32'hFFFF_FFBE);

    // Misaligned word load.
    run_req(1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
    check("lw_mis_lat", 32'(lat),       32'd1);
    check("lw_mis_err", {31'h0, r_err}, 32'h1);
    check("lw_mis_rd",  r_rdata,        32'h0);

    // Misaligned half store: no write.
    run_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h0000_1234);
    check("sh_mis_err", {31'h0, r_err}, 32'h1);
    check("sh_mis_wc",  32'(wr_cnt),    32'd0);
    check("sh_mis_lat", 32'(lat),       32'd1);
    check("sh_mis_mem", mem[4],         32'hDE5A_BEEF);

    // Illegal size.
    run_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    check("sz3_err",    {31'h0, r_err}, 32'h1);
    check("sz3_lat",    32'(lat),       32'd1);

    // Word store just past the end of memory.
    run_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFE_F00D);
`ifdef LSU_ADDR_CHECK_EN
    check("rng_err",    {31'h0, r_err}, 32'h1);
    check("rng_wcnt",   32'(wr_cnt),    32'd0);
    check("rng_lat",    32'(lat),       32'd1);
`else
    check("rng_err",    {31'h0, r_err}, 32'h0);
    check("rng_wcnt",   32'(wr_cnt),    32'd1);
    check("rng_waddr",  wr_addr,        32'd64);
    check("rng_lat",    32'(lat),       32'd2);
`endif

    // Reset while a byte store sits in RMW_RD.
    saved            = mem[4];
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h11;
    bus.req_wdata    = 32'h0000_00A5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstm_busy",  {31'h0, bus.req_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("rstm_wen",   {31'h0, bus.mem_write_en}, 32'h0);
    check("rstm_ready", {31'h0, bus.req_ready},    32'h1);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0 || bus.mem_write_en !== 1'b0) seen++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0 || bus.mem_write_en !== 1'b0) seen++;
    end
    check("rstm_quiet", 32'(seen),             32'd0);
    check("rstm_mem",   mem[4],                saved);
    check("rstm_rdy2",  {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Half store after the aborted request.
    run_req(1'b1, 2'd1, 1'b0, 32'h10, 32'hABCD_1234);
    check("sh_lat",     32'(lat),     32'd3);
    check("sh_wdata",   wr_data,      32'hDE5A_1234);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("lw2_rdata",  r_rdata,      32'hDE5A_1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
